// File: rtl/div_sequencer.sv
// Operand registering, settle timing and HI/LO capture around an external
// combinational signed divider, with a start/busy/done handshake.
module div_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   opa,
    input  logic [WIDTH-1:0]   opb,
    output logic [WIDTH-1:0]   div_a,
    output logic [WIDTH-1:0]   div_b,
    input  logic [2*WIDTH-1:0] div_result,
    output logic               busy,
    output logic               done,
    output logic               dbz,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DBZ,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div_a <= '0;
            r_div_b <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_div_a <= opa;
                        r_div_b <= opb;
                        r_busy  <= 1'b1;
                        // A zero divisor never waits on the divider output.
                        if (opb == '0) begin
                            r_state <= S_DBZ;
                        end else begin
                            r_cnt   <= 4'(SETTLE_CYCLES - 1);
                            r_state <= S_SETTLE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_hi    <= div_result[2*WIDTH-1:WIDTH];
                        r_lo    <= div_result[WIDTH-1:0];
                        r_dbz   <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DBZ: begin
                    // Dividend is taken from the operand register: opa may have moved on.
                    r_hi    <= r_div_a;
                    r_lo    <= '1;
                    r_dbz   <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign div_a = r_div_a;
    assign div_b = r_div_b;
    assign busy  = r_busy;
    assign done  = r_done;
    assign dbz   = r_dbz;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed plus randomized bench for div_sequencer; a behavioural divider
// drives div_result and a plain-arithmetic model predicts hi/lo/dbz/timing.
module tb_div_sequencer;

    localparam int W  = 32;
    localparam int SC = 2;

    logic           clk;
    logic           clr;
    logic           start;
    logic [W-1:0]   opa;
    logic [W-1:0]   opb;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic [2*W-1:0] div_result;
    logic           busy;
    logic           done;
    logic           dbz;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;
    logic         exp_dbz = 1'b0;

    div_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .clr(clr), .start(start), .opa(opa), .opb(opb),
        .div_a(div_a), .div_b(div_b), .div_result(div_result),
        .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed truncating division done in 64 bits so -2^31 / -1 wraps cleanly.
    function automatic logic [63:0] sdiv(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // External divider: garbage pattern on a zero divisor so a wrong capture shows.
    always_comb begin
        div_result = 64'hA5A5_5A5A_A5A5_5A5A;
        if (div_b != '0) div_result = sdiv(div_a, div_b);
    end

    function automatic logic [63:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return {a, 32'hFFFF_FFFF};
        return sdiv(a, b);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; issues start there, returns at the negedge of the done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
        logic [63:0] e;
        int lat;
        e   = ref_result(a, b);
        lat = (b == '0) ? 1 : SC;
        start = 1'b1; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0; opa = $urandom; opb = $urandom;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("busy_in_flight", busy, 1);
            chk("done_in_flight", done, 0);
            chk("div_a_hold", div_a, a);
            chk("div_b_hold", div_b, b);
            if (poke) begin start = 1'b1; opa = 1; opb = 1; end
        end
        @(negedge clk);
        exp_hi = e[63:32]; exp_lo = e[31:0]; exp_dbz = (b == '0);
        chk("done_pulse", done, 1);
        chk("busy_after", busy, 0);
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
        chk("dbz", dbz, exp_dbz);
        start = 1'b0;
    endtask

    task automatic idle_cycle();
        start = 1'b0; opa = $urandom; opb = $urandom;
        @(negedge clk);
        chk("done_cleared", done, 0);
        chk("busy_idle", busy, 0);
        chk("hi_hold", hi, exp_hi);
        chk("lo_hold", lo, exp_lo);
        chk("dbz_hold", dbz, exp_dbz);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        // Reset, with start asserted to show clr wins.
        clr = 1'b1; start = 1'b1; opa = 32'd55; opb = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_divab", {div_a, div_b}, 64'd0);
        clr = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_rst_done", done, 0);

        run_op(32'd100, 32'd7, 1'b0);  idle_cycle();
        run_op(-32'sd100, 32'd7, 1'b0); idle_cycle();
        chk("neg_div_lo", lo, 32'hFFFF_FFF2);
        chk("neg_div_hi", hi, 32'hFFFF_FFFE);
        run_op(32'd100, -32'sd7, 1'b0); idle_cycle();
        chk("neg_dvs_lo", lo, 32'hFFFF_FFF2);
        chk("neg_dvs_hi", hi, 32'd2);
        run_op(32'd55, 32'd0, 1'b0);   idle_cycle();
        run_op(32'd9, 32'd3, 1'b0);    idle_cycle();
        chk("dbz_cleared", dbz, 0);
        run_op(32'd100, 32'd7, 1'b1);  idle_cycle();

        // clr while in flight: everything zero, no done pulse afterwards.
        start = 1'b1; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("clr_pre_busy", busy, 1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_done", done, 0);
        chk("clr_dbz", dbz, 0);
        chk("clr_hilo", {hi, lo}, 64'd0);
        chk("clr_divab", {div_a, div_b}, 64'd0);
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        repeat (3) idle_cycle();
        run_op(32'd100, 32'd7, 1'b0); idle_cycle();

        // Back-to-back into the overflow corner.
        run_op(32'd5, 32'd2, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);
        idle_cycle();

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 9)) : 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            run_op(ra, rb, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle_cycle();
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Sequencing and result-capture stage wrapped around the team's combinational signed divider.
- Registers the operands that drive the divider's dividend/divisor inputs, waits a fixed settle time, then latches the 64-bit {remainder, quotient} into HI/LO holding registers.
- Provides a start/busy/done handshake to the control unit and short-circuits divide-by-zero.
- Sits between the datapath operand registers and the HI/LO register pair.

Parameters:
- WIDTH, 32, operand and quotient/remainder width; the divider output is 2*WIDTH.
- SETTLE_CYCLES, 2, clock edges allowed for the combinational divider to settle; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, synchronous, active-high.
- start  in  1  request a divide; sampled only when accepting.
- opa  in  WIDTH  signed dividend.
- opb  in  WIDTH  signed divisor.
- div_a  out  WIDTH  registered dividend to divider.
- div_b  out  WIDTH  registered divisor to divider.
- div_result  in  2*WIDTH  divider output: [2W-1:W] remainder, [W-1:0] quotient.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when hi/lo are updated.
- dbz  out  1  divide-by-zero flag for the last completed operation.
- hi  out  WIDTH  captured remainder.
- lo  out  WIDTH  captured quotient.

Behaviour:
- Reset: clk rising edge with clr=1 forces state IDLE, busy=0, done=0, dbz=0, hi=0, lo=0, div_a=0, div_b=0, settle counter=0. clr overrides start and any in-flight operation; no capture happens on the reset edge.
- States: IDLE, SETTLE, DONE.
- IDLE or DONE with start=1 at edge T:
  - div_a<=opa, div_b<=opb, done<=0.
  - If opb==0: state DBZ_CAPTURE path. Next edge T+1: hi<=opa, lo<=all ones, dbz<=1, done<=1, state DONE.
  - Else: counter<=SETTLE_CYCLES-1, state SETTLE.
- SETTLE: busy=1.
  - Counter !=0: decrement.
  - Counter ==0 at edge: hi<=div_result[2W-1:W], lo<=div_result[W-1:0], dbz<=0, done<=1, state DONE.
- Timing: with opb!=0, hi/lo/done are visible after edge T+SETTLE_CYCLES (SETTLE_CYCLES+1 cycles including the start cycle). Divide-by-zero completes after edge T+1.
- DONE: done=1 for exactly one cycle.
  - start=0: next edge done<=0, state IDLE.
  - start=1: accepted as a new request (back-to-back); done<=0 on that edge.
- busy is a registered output: 1 in SETTLE and during the divide-by-zero capture cycle, 0 in IDLE/DONE.
- start while busy=1 is ignored; operand registers hold.
- hi, lo and dbz hold their values until the next capture or clr.
- Arithmetic: no modification of div_result. -2^31 / -1 yields lo=0x80000000, hi=0. Remainder sign follows the dividend; quotient truncates toward zero.
- opa/opb are don't-care except at the accepting edge.

Test Plan:
- SETTLE_CYCLES=2: start with opa=100, opb=7 at edge T -> busy=1 for T+1..T+2; after edge T+2 done=1, lo=14, hi=2, dbz=0; done=0 after T+3.
- opa=-100, opb=7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE. Then opa=100, opb=-7 -> lo=0xFFFFFFF2, hi=2.
- opa=55, opb=0 -> after edge T+1 done=1, hi=55, lo=0xFFFFFFFF, dbz=1. A following 9/3 clears dbz and gives lo=3, hi=0.
- Start 100/7, then pulse start with opa=1, opb=1 while busy -> ignored; result is still lo=14, hi=2 with a single done pulse.
- Start 100/7, assert clr at edge T+1 -> all outputs 0, state IDLE, no done pulse. A fresh start then completes normally.
- Start held high in the DONE cycle with opa=-2^31, opb=-1 -> new operation accepted with no idle cycle; lo=0x80000000, hi=0.
